rf_alu_sequencer: RTL and testbench

Multi-cycle control sequencer for the 16-bit register-file + ALU datapath. It accepts one instruction word at a time, walks it through decode, execute, memory and write-back states, and drives the datapath controls: RA1, RA2, WA, RW, ALUOp, SrcB, LM, signE and the memory strobes. It sits between the instruction source (fetch logic or a bench) and the integrated RF/ALU block, so that block is never driven by hand.

---
 rtl/rf_alu_sequencer_if.sv | 36 +++
 rtl/rf_alu_sequencer.sv | 148 ++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_alu_sequencer_if.sv
// Handshake and datapath-control bundle between the instruction/memory side,
// the rf_alu_sequencer and the RF/ALU block it drives.
interface rf_alu_sequencer_if;
  logic        start;
  logic [15:0] instr;
  logic        memready;

  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  ra1;
  logic [3:0]  ra2;
  logic [3:0]  wa;
  logic        rw;
  logic [2:0]  aluop;
  logic        srcb;
  logic        lm;
  logic [15:0] signe;
  logic        memread;
  logic        memwrite;
  logic [15:0] retired;

  // Instruction source / memory / datapath side.
  modport master (
    output start, instr, memready,
    input  busy, done, err, ra1, ra2, wa, rw, aluop, srcb, lm, signe,
           memread, memwrite, retired
  );

  // Sequencer side.
  modport slave (
    input  start, instr, memready,
    output busy, done, err, ra1, ra2, wa, rw, aluop, srcb, lm, signe,
           memread, memwrite, retired
  );
endinterface

// File: rtl/rf_alu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RF + ALU datapath: walks one
// instruction through DECODE/EXEC/MEM/WB and drives registered (Moore) controls.
module rf_alu_sequencer #(
  parameter int IMM_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_alu_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b001,
    ALU_SUB = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  state_t state;
  state_t state_nxt;

  // Only op and rd are needed after acceptance; the source operands live in
  // the ra1/ra2/signe output registers, which hold until the next accept.
  logic [3:0] ir_op;
  logic [3:0] ir_rd;

  logic [3:0]       in_op;
  logic [3:0]       in_rd;
  logic [3:0]       in_rs;
  logic [3:0]       in_rt;
  logic [IMM_W-1:0] in_imm;

  logic accept;
  logic illegal;
  logic done_nxt;
  logic err_nxt;

  assign in_op  = bus.instr[15:12];
  assign in_rd  = bus.instr[11:8];
  assign in_rs  = bus.instr[7:4];
  assign in_rt  = bus.instr[3:0];
  assign in_imm = bus.instr[IMM_W-1:0];

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;  // add, addi and the lw/sw address sum
    endcase
  endfunction

  function automatic logic is_rtype(input logic [3:0] op);
    return (op <= OP_SLT);
  endfunction

  assign accept  = (state == IDLE) && bus.start;
  assign illegal = ir_op[3];

  // NOTE: state registers are written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: state_nxt is defaulted before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = DECODE;
      DECODE:  state_nxt = illegal ? IDLE : EXEC;
      EXEC:    state_nxt = ((ir_op == OP_LW) || (ir_op == OP_SW)) ? MEM : WB;
      MEM: begin
        if (bus.memready) state_nxt = (ir_op == OP_LW) ? WB : IDLE;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every return to IDLE other than by reset retires an instruction.
  assign done_nxt = (state != IDLE) && (state_nxt == IDLE);
  assign err_nxt  = (state == DECODE) && illegal;

  // Outputs are registered from the next state so each one is valid for the
  // whole of the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_op        <= 4'd0;
      ir_rd        <= 4'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.rw       <= 1'b0;
      bus.wa       <= 4'd0;
      bus.lm       <= 1'b0;
      bus.memread  <= 1'b0;
      bus.memwrite <= 1'b0;
      bus.ra1      <= 4'd0;
      bus.ra2      <= 4'd0;
      bus.aluop    <= 3'd0;
      bus.srcb     <= 1'b0;
      bus.signe    <= 16'd0;
      bus.retired  <= 16'd0;
    end else begin
      bus.busy     <= (state_nxt != IDLE);
      bus.done     <= done_nxt;
      bus.err      <= err_nxt;
      bus.rw       <= (state_nxt == WB);
      bus.wa       <= (state_nxt == WB) ? ir_rd : 4'd0;
      bus.lm       <= (state_nxt == WB) && (ir_op == OP_LW);
      bus.memread  <= (state_nxt == MEM) && (ir_op == OP_LW);
      bus.memwrite <= (state_nxt == MEM) && (ir_op == OP_SW);

      if (accept) begin
        ir_op     <= in_op;
        ir_rd     <= in_rd;
        bus.ra1   <= in_rs;
        // sw reads its store data through port 2, addressed by rd.
        bus.ra2   <= (in_op == OP_SW) ? in_rd : in_rt;
        bus.aluop <= alu_sel(in_op);
        bus.srcb  <= !is_rtype(in_op);
        bus.signe <= {{(16-IMM_W){in_imm[IMM_W-1]}}, in_imm};
      end

      if (done_nxt) bus.retired <= bus.retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Randomized self-checking bench: a stand-in RF/ALU/memory is driven by the
// sequencer, and results are compared against an instruction-level model.
module tb_rf_alu_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_alu_sequencer_if sif();

  rf_alu_sequencer #(.IMM_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  // Stand-in datapath controlled only by the sequencer outputs.
  logic [15:0] rf   [16];
  logic [15:0] dmem [256];
  logic [15:0] alu_a, alu_b, aluo, md;
  logic        poke_en, poke_mem;
  logic [7:0]  poke_a;
  logic [15:0] poke_d;

  always_comb begin
    alu_a = rf[sif.ra1];
    alu_b = sif.srcb ? sif.signe : rf[sif.ra2];
    case (sif.aluop)
      3'b000:  aluo = alu_a + alu_b;
      3'b001:  aluo = alu_a & alu_b;
      3'b010:  aluo = alu_a - alu_b;
      3'b011:  aluo = alu_a | alu_b;
      3'b100:  aluo = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      default: aluo = 16'hDEAD;
    endcase
    md = dmem[aluo[7:0]];
  end

  always @(posedge clk) begin
    if (poke_en) begin
      if (poke_mem) dmem[poke_a] <= poke_d;
      else          rf[poke_a[3:0]] <= poke_d;
    end
    if (sif.rw) rf[sif.wa] <= sif.lm ? md : aluo;
    if (sif.memwrite && sif.memready) dmem[aluo[7:0]] <= rf[sif.ra2];
  end

  // Instruction-level reference state.
  logic [15:0] m_rf  [16];
  logic [15:0] m_mem [256];
  logic [15:0] m_retired;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // All stimulus tasks start and end at a falling edge.
  task automatic poke(input bit is_mem, input logic [7:0] a, input logic [15:0] d);
    poke_en  = 1'b1;
    poke_mem = is_mem;
    poke_a   = a;
    poke_d   = d;
    if (is_mem) m_mem[a] = d;
    else        m_rf[a[3:0]] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] ins, input int n_mem, input bit spur);
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] imm_x, b, res, wdata;
    logic [7:0]  addr;
    logic [2:0]  exp_alu;
    bit          legal, rtype, is_lw, is_sw, writes, err_at_done;
    int          lat, done_c, busy_cnt, rw_cnt, mr_cnt, mw_cnt, err_cnt, mem_seen;

    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    imm_x  = {{12{rt[3]}}, rt};
    legal  = (op < 4'd8);
    rtype  = (op < 4'd5);
    is_lw  = (op == 4'd6);
    is_sw  = (op == 4'd7);
    writes = legal && !is_sw;
    lat    = !legal ? 2 : is_lw ? 4 + n_mem : is_sw ? 3 + n_mem : 4;
    b      = rtype ? m_rf[rt] : imm_x;
    case (op)
      4'd1:    res = m_rf[rs] - b;
      4'd2:    res = m_rf[rs] & b;
      4'd3:    res = m_rf[rs] | b;
      4'd4:    res = ($signed(m_rf[rs]) < $signed(b)) ? 16'd1 : 16'd0;
      default: res = m_rf[rs] + b;
    endcase
    addr    = res[7:0];
    wdata   = is_lw ? m_mem[addr] : res;
    exp_alu = (op == 4'd1) ? 3'b010 : (op == 4'd2) ? 3'b001 :
              (op == 4'd3) ? 3'b011 : (op == 4'd4) ? 3'b100 : 3'b000;

    done_c = 0; busy_cnt = 0; rw_cnt = 0; mr_cnt = 0; mw_cnt = 0;
    err_cnt = 0; mem_seen = 0; err_at_done = 1'b0;
    sif.start = 1'b1;
    sif.instr = ins;

    for (int c = 1; c <= 40 && done_c == 0; c++) begin
      @(negedge clk);
      if (sif.busy)     busy_cnt++;
      if (sif.memread)  mr_cnt++;
      if (sif.memwrite) mw_cnt++;
      if (sif.err)      err_cnt++;
      if (sif.rw) begin
        rw_cnt++;
        check("wa", 32'(sif.wa), 32'(rd));
        check("lm", 32'(sif.lm), 32'(is_lw));
      end
      if (c == 2 && legal) begin
        check("exec_aluop", 32'(sif.aluop), 32'(exp_alu));
        check("exec_srcb",  32'(sif.srcb),  32'(!rtype));
        check("exec_ra1",   32'(sif.ra1),   32'(rs));
        check("exec_signe", 32'(sif.signe), 32'(imm_x));
        if (rtype || is_sw) check("exec_ra2", 32'(sif.ra2), 32'(is_sw ? rd : rt));
      end
      if (sif.done) begin
        done_c      = c;
        err_at_done = sif.err;
        check("retired", 32'(sif.retired), 32'(16'(m_retired + 16'd1)));
      end
      if (sif.memread || sif.memwrite) begin
        mem_seen++;
        sif.memready = (mem_seen == n_mem);
      end else begin
        sif.memready = 1'($urandom_range(0, 1));
      end
      sif.start = spur && (c < lat) && !sif.done;
      if (sif.start) sif.instr = 16'($urandom);
    end

    check("done_latency", done_c, lat);
    check("err_at_done", 32'(err_at_done), 32'(!legal));
    check("err_pulses", err_cnt, legal ? 0 : 1);
    check("busy_cycles", busy_cnt, lat - 1);
    check("rw_cycles", rw_cnt, writes ? 1 : 0);
    check("memread_cycles", mr_cnt, is_lw ? n_mem : 0);
    check("memwrite_cycles", mw_cnt, is_sw ? n_mem : 0);

    m_retired = m_retired + 16'd1;
    if (writes) begin
      m_rf[rd] = wdata;
      check("rf_result", 32'(rf[rd]), 32'(m_rf[rd]));
    end
    if (is_sw) begin
      m_mem[addr] = m_rf[rd];
      check("mem_store", 32'(dmem[addr]), 32'(m_mem[addr]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rw_seen, done_seen;
    rst = 1'b1;
    sif.start = 1'b0; sif.instr = 16'd0; sif.memready = 1'b0;
    poke_en = 1'b0; poke_mem = 1'b0; poke_a = 8'd0; poke_d = 16'd0;
    m_retired = 16'd0;
    repeat (3) @(negedge clk);

    check("rst_busy",     32'(sif.busy),     0);
    check("rst_done",     32'(sif.done),     0);
    check("rst_err",      32'(sif.err),      0);
    check("rst_rw",       32'(sif.rw),       0);
    check("rst_lm",       32'(sif.lm),       0);
    check("rst_srcb",     32'(sif.srcb),     0);
    check("rst_memread",  32'(sif.memread),  0);
    check("rst_memwrite", 32'(sif.memwrite), 0);
    check("rst_ra1",      32'(sif.ra1),      0);
    check("rst_ra2",      32'(sif.ra2),      0);
    check("rst_wa",       32'(sif.wa),       0);
    check("rst_aluop",    32'(sif.aluop),    0);
    check("rst_signe",    32'(sif.signe),    0);
    check("rst_retired",  32'(sif.retired),  0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)  poke(1'b0, 8'(i), 16'($urandom));
    for (int i = 0; i < 256; i++) poke(1'b1, 8'(i), 16'($urandom));
    poke(1'b0, 8'd0, 16'd4);
    poke(1'b0, 8'd1, 16'd2);
    poke(1'b1, 8'd8, 16'h1234);

    run_instr(16'h9000, 1, 1'b0);

    // Reset held for two cycles while a lw waits in MEM.
    sif.start = 1'b1; sif.instr = 16'h6500; sif.memready = 1'b0;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_lw_memread", 32'(sif.memread), 1);
    rst = 1'b1;
    rw_seen = 1'b0; done_seen = 1'b0;
    @(negedge clk);
    check("rst_drops_memread", 32'(sif.memread), 0);
    rw_seen = rw_seen | sif.rw; done_seen = done_seen | sif.done;
    @(negedge clk);
    rw_seen = rw_seen | sif.rw; done_seen = done_seen | sif.done;
    check("rst_abort_busy",    32'(sif.busy),    0);
    check("rst_abort_retired", 32'(sif.retired), 0);
    check("rst_abort_rw",      32'(rw_seen),     0);
    check("rst_abort_done",    32'(done_seen),   0);
    rst = 1'b0;
    m_retired = 16'd0;

    run_instr(16'h1201, 1, 1'b0);
    check("sub_r2", 32'(rf[2]), 32'h0002);

    poke(1'b0, 8'd0, 16'd8);
    run_instr(16'h5300, 1, 1'b0);
    check("addi_r3", 32'(rf[3]), 32'h0008);
    run_instr(16'h530F, 1, 1'b0);
    check("addi_neg_r3", 32'(rf[3]), 32'h0007);
    check("signe_hold", 32'(sif.signe), 32'hFFFF);

    run_instr(16'h6500, 4, 1'b0);
    check("lw_r5", 32'(rf[5]), 32'h1234);
    run_instr(16'h7501, 1, 1'b0);
    check("sw_mem9", 32'(dmem[9]), 32'h1234);
    run_instr(16'h9000, 1, 1'b0);
    run_instr(16'h0123, 1, 1'b1);

    for (int k = 0; k < 80; k++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 9)), 12'($urandom)};
      run_instr(ins, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
    end

    force sif.retired = 16'hFFFF;
    @(negedge clk);
    release sif.retired;
    m_retired = 16'hFFFF;
    run_instr(16'hA000, 1, 1'b0);
    check("retired_wrap", 32'(sif.retired), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
